// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Optional performance counters (cycle_cnt, instret_cnt) are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_fsm #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        zero,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       pc_update, branch;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: every output and next-state term gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (wait_cnt_q == WAIT_LAST) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                // ALU computes the branch/jump target from oldPC + imm while op is decoded.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // Writes the jump target into PC while the ALU forms oldPC + 4 for the link register.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        pc_write = pc_update | (branch & zero);

        if (reset) begin
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal_op = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // These states always return to FETCH, so being in one marks a retiring instruction.
    logic retire;
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                    (state_q == S_ALUWB) || (state_q == S_BEQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle expected control words are queued
// as stimulus is driven and compared when the DUT presents its outputs.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // {adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal_op}
    localparam logic [14:0] E_ZERO   = 15'b0_0_0_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_FETCH  = 15'b0_1_0_1_1_0_10_00_10_00_0;
    localparam logic [14:0] E_FWAIT  = 15'b0_1_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_DECODE = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] E_ILL    = 15'b0_0_0_0_0_0_00_01_01_00_1;
    localparam logic [14:0] E_MEMADR = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] E_MEMRD  = 15'b1_1_0_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_MEMWB  = 15'b0_0_0_0_0_1_01_00_00_00_0;
    localparam logic [14:0] E_MEMWR  = 15'b1_0_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] E_EXECR  = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] E_EXECI  = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] E_ALUWB  = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] E_JAL    = 15'b0_0_0_0_1_0_00_01_10_00_0;
    localparam logic [14:0] E_BEQT   = 15'b0_0_0_0_1_0_00_10_00_01_0;
    localparam logic [14:0] E_BEQN   = 15'b0_0_0_0_0_0_00_10_00_01_0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset1 = 1'b1, reset2 = 1'b1;
    logic [6:0] op1 = '0, op2 = '0;
    logic       zero = 1'b0;

    logic       adr_src1, mem_read1, mem_write1, ir_write1, pc_write1, reg_write1, illegal_op1;
    logic [1:0] result_src1, alu_src_a1, alu_src_b1, alu_op1;
    logic       adr_src2, mem_read2, mem_write2, ir_write2, pc_write2, reg_write2, illegal_op2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2, alu_op2;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt1, instret_cnt1, cycle_cnt2, instret_cnt2;
`endif

    multicycle_control_fsm #(.FETCH_WAIT(0)) dut1 (
        .clk(clk), .reset(reset1), .op(op1), .zero(zero),
        .adr_src(adr_src1), .mem_read(mem_read1), .mem_write(mem_write1),
        .ir_write(ir_write1), .pc_write(pc_write1), .reg_write(reg_write1),
        .result_src(result_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .alu_op(alu_op1), .illegal_op(illegal_op1)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt1), .instret_cnt(instret_cnt1)
`endif
    );

    multicycle_control_fsm #(.FETCH_WAIT(2)) dut2 (
        .clk(clk), .reset(reset2), .op(op2), .zero(zero),
        .adr_src(adr_src2), .mem_read(mem_read2), .mem_write(mem_write2),
        .ir_write(ir_write2), .pc_write(pc_write2), .reg_write(reg_write2),
        .result_src(result_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .alu_op(alu_op2), .illegal_op(illegal_op2)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt2), .instret_cnt(instret_cnt2)
`endif
    );

    logic [14:0] act1, act2;
    assign act1 = {adr_src1, mem_read1, mem_write1, ir_write1, pc_write1, reg_write1,
                   result_src1, alu_src_a1, alu_src_b1, alu_op1, illegal_op1};
    assign act2 = {adr_src2, mem_read2, mem_write2, ir_write2, pc_write2, reg_write2,
                   result_src2, alu_src_a2, alu_src_b2, alu_op2, illegal_op2};

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];
    string       name_q[$];

    // Reference counter model per DUT (index 0 = dut1, 1 = dut2).
    logic [31:0] cyc_m[2];
    logic [31:0] ins_m[2];
    bit          cnt_valid[2] = '{1'b0, 1'b0};

    // One clock cycle on the selected DUT: drive just after the edge, compare at the falling edge.
    task automatic step(input bit sel, input logic r, input logic [6:0] o, input logic z,
                        input logic [14:0] exp, input bit ret, input string nm);
        logic [14:0] got, want;
        string       n;
        int          idx;
        idx = sel ? 1 : 0;
        @(posedge clk);
        #1;
        if (sel) begin reset2 = r; op2 = o; end
        else     begin reset1 = r; op1 = o; end
        zero = z;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        got  = sel ? act2 : act1;
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: ctrl got %b expected %b", n, got, want);
        end
`ifdef CTRL_PERF_CNT_EN
        if (cnt_valid[idx]) begin
            checks++;
            if ((sel ? cycle_cnt2 : cycle_cnt1) !== cyc_m[idx]) begin
                errors++;
                $display("FAIL %s_cycle_cnt: got %0d expected %0d", n,
                         sel ? cycle_cnt2 : cycle_cnt1, cyc_m[idx]);
            end
            checks++;
            if ((sel ? instret_cnt2 : instret_cnt1) !== ins_m[idx]) begin
                errors++;
                $display("FAIL %s_instret_cnt: got %0d expected %0d", n,
                         sel ? instret_cnt2 : instret_cnt1, ins_m[idx]);
            end
        end
`endif
        if (r) begin
            cyc_m[idx] = '0;
            ins_m[idx] = '0;
            cnt_valid[idx] = 1'b1;
        end else if (cnt_valid[idx]) begin
            cyc_m[idx] = cyc_m[idx] + 32'd1;
            if (ret) ins_m[idx] = ins_m[idx] + 32'd1;
        end
    endtask

    // Full instruction on dut1 (FETCH_WAIT=0), from FETCH through its last state.
    task automatic run_instr(input logic [6:0] o, input logic z, input string nm);
        logic [14:0] seq[$];
        bit          legal;
        legal = 1'b1;
        seq.push_back(E_FETCH);
        seq.push_back(E_DECODE);
        case (o)
            OP_LW:   begin seq.push_back(E_MEMADR); seq.push_back(E_MEMRD); seq.push_back(E_MEMWB); end
            OP_SW:   begin seq.push_back(E_MEMADR); seq.push_back(E_MEMWR); end
            OP_R:    begin seq.push_back(E_EXECR);  seq.push_back(E_ALUWB); end
            OP_I:    begin seq.push_back(E_EXECI);  seq.push_back(E_ALUWB); end
            OP_JAL:  begin seq.push_back(E_JAL);    seq.push_back(E_ALUWB); end
            OP_BEQ:  seq.push_back(z ? E_BEQT : E_BEQN);
            default: begin seq[1] = E_ILL; legal = 1'b0; end
        endcase
        for (int i = 0; i < seq.size(); i++)
            step(1'b0, 1'b0, o, z, seq[i], legal && (i == seq.size() - 1),
                 $sformatf("%s_c%0d", nm, i + 1));
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, OP_LW, 1'b1, E_ZERO, 1'b0, "reset_c1");
        step(1'b0, 1'b1, OP_LW, 1'b1, E_ZERO, 1'b0, "reset_c2");
    endtask

    task automatic test_lw();
        run_instr(OP_LW, 1'b1, "lw");
    endtask

    task automatic test_sw();
        run_instr(OP_SW, 1'b1, "sw");
    endtask

    task automatic test_alu();
        run_instr(OP_R, 1'b1, "rtype");
        run_instr(OP_I, 1'b1, "itype");
        run_instr(OP_JAL, 1'b1, "jal");
    endtask

    task automatic test_beq();
        run_instr(OP_BEQ, 1'b1, "beq_taken");
        run_instr(OP_BEQ, 1'b0, "beq_not_taken");
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 1'b1, "illegal");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[7];
        logic [6:0] o;
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, 7'b0000000};
        for (int k = 0; k < 12; k++) begin
            o = ops[$urandom_range(0, 6)];
            run_instr(o, 1'(($urandom_range(0, 1))), $sformatf("b2b%0d", k));
        end
        // Final FETCH confirms the last instruction handed back cleanly.
        step(1'b0, 1'b0, OP_R, 1'b1, E_FETCH, 1'b0, "b2b_tail");
    endtask

    // dut2 has FETCH_WAIT=2: three-cycle FETCH, then reset lands in MEMREAD and aborts the lw.
    task automatic test_fetch_wait_reset();
        step(1'b1, 1'b1, OP_LW, 1'b1, E_ZERO,   1'b0, "fw_reset");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_FWAIT,  1'b0, "fw_fetch1");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_FWAIT,  1'b0, "fw_fetch2");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_FETCH,  1'b0, "fw_fetch3");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_DECODE, 1'b0, "fw_decode");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_MEMADR, 1'b0, "fw_memadr");
        step(1'b1, 1'b1, OP_LW, 1'b1, E_ZERO,   1'b0, "fw_reset_in_memread");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_FWAIT,  1'b0, "fw_refetch1");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_FWAIT,  1'b0, "fw_refetch2");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_FETCH,  1'b0, "fw_refetch3");
        step(1'b1, 1'b0, OP_LW, 1'b1, E_DECODE, 1'b0, "fw_redecode");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_fetch_wait_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
